hbm_channel_responder: RTL and testbench
========================================

# hbm_channel_responder

Memory-side responder for one HBM2 pseudo-channel. It is the other end of the core's `hbm_addr`/`hbm_data_out`/`hbm_we` master interface: it accepts write and read requests, stores 256-bit words in on-chip RAM, and returns read data after a fixed latency. It also injects periodic refresh stalls. Bench and emulation builds instantiate one per channel so the CX swapper and RoCE engine can run without the HBM IP.

## Interface
- `ADDR_W`, default 32: byte-address width.
- `DATA_W`, default 256: word width; fixed at 256, byte offset bits [4:0] are ignored.
- `DEPTH_LOG2`, default 10: log2 of the number of stored words.
- `RD_LATENCY`, default 4: cycles from read accept to `rvalid`; legal range 2..8.
- `REFRESH_INTERVAL`, default 1024: RUN cycles between refresh stalls; must be ≥ 2.
- `REFRESH_CYCLES`, default 8: length of each refresh stall; must be ≥ 1.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `hbm_req`  in  1  request valid.
- `hbm_ready`  out  1  responder can accept a request.
- `hbm_addr`  in  ADDR_W  byte address.
- `hbm_we`  in  1  1 = write, 0 = read.
- `hbm_data_out`  in  DATA_W  write data, from the master.
- `hbm_data_in`  out  DATA_W  read data, to the master.
- `rvalid`  out  1  `hbm_data_in` is valid this cycle.
- `refresh_active`  out  1  responder is in the REFRESH state.
- `err_oob`  out  1  sticky flag: an out-of-range address was accepted.
- `wr_count`  out  32  accepted writes, wraps modulo 2^32.
- `rd_count`  out  32  accepted reads, wraps modulo 2^32.

## Operation
- Accept: a request is accepted at a rising edge when `hbm_req && hbm_ready`. At most one request is accepted per cycle.
- Word index is `hbm_addr[5 +: DEPTH_LOG2]`.
- Out of range means any bit of `hbm_addr[ADDR_W-1 : 5+DEPTH_LOG2]` is set.
- Write: commits at the accept edge. Out-of-range writes are dropped and set `err_oob`. `wr_count` increments in both cases.
- Read: the RAM is read at the accept edge, so a read sees every write accepted in earlier cycles. The result travels a RD_LATENCY-deep shift pipeline that carries the valid bit and the data.
  - Out-of-range reads return all zeros with `rvalid` still asserted, and set `err_oob`.
  - `rd_count` increments on every accepted read.
- FSM has two states, RUN and REFRESH.
  - RUN: `ref_cnt` increments every cycle. At the edge where `ref_cnt == REFRESH_INTERVAL-1`: go to REFRESH, clear `ref_cnt`, drive `hbm_ready` 0.
  - REFRESH: `rf_cnt` counts REFRESH_CYCLES cycles. At the edge where `rf_cnt == REFRESH_CYCLES-1`: go to RUN, drive `hbm_ready` 1.
  - `refresh_active` equals (state == REFRESH).
  - A request held while `hbm_ready` is 0 is not accepted. The master must hold it until accepted.
- The read pipeline keeps advancing during REFRESH. Reads in flight complete on schedule.
- `err_oob` clears only on `rst`.

## Timing
- Reset (asynchronous, immediate): `hbm_ready`=0, `hbm_data_in`=0, `rvalid`=0, `refresh_active`=0, `err_oob`=0, `wr_count`=0, `rd_count`=0. State=RUN, `ref_cnt`=0, read pipeline flushed.
- RAM contents are not reset and are undefined until written.
- After reset: `hbm_ready` rises at the first rising edge after `rst` deasserts. `ref_cnt` starts counting at that same edge.
- Read latency: a read accepted at edge N gives `rvalid`=1 and data in the cycle following edge N+RD_LATENCY-1. That is exactly RD_LATENCY cycles after the accept cycle. `rvalid` is a one-cycle pulse per read.
- Back-to-back reads give back-to-back `rvalid` pulses. Throughput is one request per cycle outside REFRESH.
- Write then read of the same address in consecutive cycles returns the new data.
- A request presented in the last RUN cycle, while `hbm_ready`=1, is accepted even though `hbm_ready` drops at that edge.
- Counters and `err_oob` update at the accept edge and are visible the next cycle.
- Reset mid-operation: in-flight reads are lost and no `rvalid` is produced for them. A mid-refresh reset returns the FSM to RUN.

## Test plan
- Reset, then 1 cycle, then write 0xA5…A5 to byte address 0x40, then read 0x40 -> `rvalid` pulses RD_LATENCY=4 cycles after the read accept with data 0xA5…A5; `wr_count`=1, `rd_count`=1.
- 16 back-to-back writes of data=i at addresses 32·i, then 16 back-to-back reads -> 16 consecutive `rvalid` pulses with data 0..15 in order. Addresses 0x1F and 0x00 map to the same word.
- Hold `hbm_req` continuously (reads) with REFRESH_INTERVAL=16, REFRESH_CYCLES=3 -> `hbm_ready` is low for exactly 3 cycles every 19 cycles. No request is accepted while low, and reads in flight still return during refresh.
- Write to 0x8000 (bit 15 set, DEPTH_LOG2=10) -> `err_oob`=1, the write is dropped (a read of 0x0 returns the old data), and a read of 0x8000 returns 0 with `rvalid`.
- Assert `rst` two cycles after a read accept -> `rvalid` never pulses for it; counters=0; `hbm_ready`=0 until the first edge after release.
- Force `wr_count`=0xFFFFFFFF via a preload test hook or long run, then accept one write -> `wr_count`=0.

Source files
------------

// File: rtl/hbm_channel_responder.sv
// hbm_channel_responder: on-chip stand-in for one HBM2 pseudo-channel.
// Accepts one read or write per cycle and stores 256-bit words in a local RAM.
// Read data comes back through a fixed-latency shift pipeline.
// Periodic refresh windows pull hbm_ready low; reads already in flight still complete.
module hbm_channel_responder #(
  parameter int          ADDR_W           = 32,
  parameter int          DATA_W           = 256,
  parameter int          DEPTH_LOG2       = 10,
  parameter int          RD_LATENCY       = 4,
  parameter int          REFRESH_INTERVAL = 1024,
  parameter int          REFRESH_CYCLES   = 8,
  // Reset value of wr_count/rd_count; nonzero only in test builds that exercise counter wrap
  parameter logic [31:0] COUNT_PRELOAD    = 32'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hbm_req,
  output logic              hbm_ready,
  input  logic [ADDR_W-1:0] hbm_addr,
  input  logic              hbm_we,
  input  logic [DATA_W-1:0] hbm_data_out,
  output logic [DATA_W-1:0] hbm_data_in,
  output logic              rvalid,
  output logic              refresh_active,
  output logic              err_oob,
  output logic [31:0]       wr_count,
  output logic [31:0]       rd_count
);

  localparam int OFF_W = 5;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int REF_W = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int RF_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_INTERVAL - 1);
  localparam logic [RF_W-1:0]  RF_LAST  = RF_W'(REFRESH_CYCLES - 1);

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_REFRESH = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [REF_W-1:0]   ref_cnt_q, ref_cnt_d;
  logic [RF_W-1:0]    rf_cnt_q, rf_cnt_d;
  logic               ready_q, ready_d;
  logic               err_oob_q, err_oob_d;
  logic [31:0]        wr_count_q, wr_count_d;
  logic [31:0]        rd_count_q, rd_count_d;
  logic               pipe_vld_q  [RD_LATENCY];
  logic               pipe_vld_d  [RD_LATENCY];
  logic [DATA_W-1:0]  pipe_data_q [RD_LATENCY];
  logic [DATA_W-1:0]  pipe_data_d [RD_LATENCY];

  logic [DATA_W-1:0]     mem [DEPTH];
  logic                  accept;
  logic                  addr_oob;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [DATA_W-1:0]     rd_word;
  logic                  unused_addr_bits;

  assign accept   = hbm_req && ready_q;
  assign word_idx = hbm_addr[OFF_W +: DEPTH_LOG2];

  // The byte offset inside a 32-byte word carries no information for this responder
  assign unused_addr_bits = ^hbm_addr[OFF_W-1:0];

  generate
    if (ADDR_W > OFF_W + DEPTH_LOG2) begin : g_oob
      assign addr_oob = |hbm_addr[ADDR_W-1:OFF_W+DEPTH_LOG2];
    end else begin : g_no_oob
      assign addr_oob = 1'b0;
    end
  endgenerate

  // Out-of-range reads return zeros instead of an aliased word
  assign rd_word = addr_oob ? '0 : mem[word_idx];

  // Word storage; contents are intentionally not reset, and out-of-range writes are dropped
  always_ff @(posedge clk) begin
    if (accept && hbm_we && !addr_oob) begin
      mem[word_idx] <= hbm_data_out;
    end
  end

  // RUN/REFRESH sequencing; ready follows the state we are about to enter
  always_comb begin
    state_d   = state_q;
    ref_cnt_d = ref_cnt_q;
    rf_cnt_d  = rf_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (ref_cnt_q == REF_LAST) begin
          state_d   = ST_REFRESH;
          ref_cnt_d = '0;
          rf_cnt_d  = '0;
        end else begin
          ref_cnt_d = ref_cnt_q + REF_W'(1);
        end
      end
      ST_REFRESH: begin
        if (rf_cnt_q == RF_LAST) begin
          state_d  = ST_RUN;
          rf_cnt_d = '0;
        end else begin
          rf_cnt_d = rf_cnt_q + RF_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
    ready_d = (state_d == ST_RUN);
  end

  // Read pipeline: stage 0 captures the RAM word at the accept edge; later stages just shift
  always_comb begin
    pipe_vld_d[0]  = accept && !hbm_we;
    pipe_data_d[0] = (accept && !hbm_we) ? rd_word : '0;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_data_d[i] = pipe_data_q[i-1];
    end
  end

  // Request counters and the sticky out-of-range flag
  always_comb begin
    wr_count_d = wr_count_q + {31'd0, (accept && hbm_we)};
    rd_count_d = rd_count_q + {31'd0, (accept && !hbm_we)};
    err_oob_d  = err_oob_q | (accept && addr_oob);
  end

  // All control state, with an immediate reset that also drops reads in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      ref_cnt_q  <= '0;
      rf_cnt_q   <= '0;
      ready_q    <= 1'b0;
      err_oob_q  <= 1'b0;
      wr_count_q <= COUNT_PRELOAD;
      rd_count_q <= COUNT_PRELOAD;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_vld_q[i]  <= 1'b0;
        pipe_data_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ref_cnt_q  <= ref_cnt_d;
      rf_cnt_q   <= rf_cnt_d;
      ready_q    <= ready_d;
      err_oob_q  <= err_oob_d;
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_d[i];
        pipe_data_q[i] <= pipe_data_d[i];
      end
    end
  end

  assign hbm_ready      = ready_q;
  assign refresh_active = (state_q == ST_REFRESH);
  assign err_oob        = err_oob_q;
  assign wr_count       = wr_count_q;
  assign rd_count       = rd_count_q;
  assign rvalid         = pipe_vld_q[RD_LATENCY-1];
  assign hbm_data_in    = pipe_data_q[RD_LATENCY-1];

endmodule

// File: tb/tb_hbm_channel_responder.sv
// Testbench for hbm_channel_responder.
// Stimulus drives a held-until-accepted request handshake and keeps a word-level memory model.
// A negedge monitor compares read returns, counters and the refresh pattern against that model.
module tb_hbm_channel_responder;

  localparam int L     = 4;
  localparam int RI    = 16;
  localparam int RC    = 3;
  localparam int WORDS = 1024;

  typedef struct {
    logic [255:0] data;
    bit           dc;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         hbm_req = 1'b0;
  logic         hbm_we = 1'b0;
  logic [31:0]  hbm_addr = '0;
  logic [255:0] hbm_data_out = '0;
  logic         hbm_ready;
  logic [255:0] hbm_data_in;
  logic         rvalid;
  logic         refresh_active;
  logic         err_oob;
  logic [31:0]  wr_count;
  logic [31:0]  rd_count;

  // Second instance, built with preloaded counters, only for wrap-around
  logic         req2 = 1'b0;
  logic         we2 = 1'b0;
  logic         ready2;
  logic [31:0]  wr_count2;
  logic [31:0]  rd_count2;
  logic [255:0] unused_data2;
  logic         unused_rvalid2;
  logic         unused_refresh2;
  logic         unused_err2;

  int           checks = 0;
  int           fails = 0;
  int           cyc = 0;
  int           k = 0;

  exp_t         sbq[$];
  logic [255:0] model_mem [int];
  logic [31:0]  exp_wr = '0;
  logic [31:0]  exp_rd = '0;
  logic         exp_oob = 1'b0;

  hbm_channel_responder #(
    .ADDR_W(32), .DATA_W(256), .DEPTH_LOG2(10), .RD_LATENCY(L),
    .REFRESH_INTERVAL(RI), .REFRESH_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .hbm_req(hbm_req), .hbm_ready(hbm_ready),
    .hbm_addr(hbm_addr), .hbm_we(hbm_we), .hbm_data_out(hbm_data_out),
    .hbm_data_in(hbm_data_in), .rvalid(rvalid), .refresh_active(refresh_active),
    .err_oob(err_oob), .wr_count(wr_count), .rd_count(rd_count)
  );

  hbm_channel_responder #(
    .DEPTH_LOG2(4), .COUNT_PRELOAD(32'hFFFF_FFFF)
  ) dut_wrap (
    .clk(clk), .rst(rst), .hbm_req(req2), .hbm_ready(ready2),
    .hbm_addr(32'h0000_0040), .hbm_we(we2), .hbm_data_out({8{32'h1234_5678}}),
    .hbm_data_in(unused_data2), .rvalid(unused_rvalid2), .refresh_active(unused_refresh2),
    .err_oob(unused_err2), .wr_count(wr_count2), .rd_count(rd_count2)
  );

  always #5 clk = ~clk;

  // Edge counter and edges-since-reset counter used for latency and refresh expectations
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Present one request at a negedge and hold it until the DUT takes it
  task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [255:0] data);
    int   waited = 0;
    bit   done = 0;
    bit   oob;
    int   idx;
    int   acc_cyc;
    exp_t e;
    hbm_req = 1'b1;
    hbm_we = we;
    hbm_addr = addr;
    hbm_data_out = data;
    oob = (addr >= 32'(WORDS * 32));
    idx = int'(addr / 32);
    while (!done) begin
      if (hbm_ready) begin
        acc_cyc = cyc + 1;
        @(posedge clk);
        if (we) begin
          exp_wr = exp_wr + 1;
          if (oob) exp_oob = 1'b1;
          else     model_mem[idx] = data;
        end else begin
          exp_rd = exp_rd + 1;
          e.cyc  = acc_cyc + L - 1;
          e.dc   = !oob && !model_mem.exists(idx);
          e.data = (oob || e.dc) ? 256'd0 : model_mem[idx];
          if (oob) exp_oob = 1'b1;
          sbq.push_back(e);
        end
        done = 1;
      end else begin
        waited++;
        if (waited > 64) begin
          checks++;
          fails++;
          $display("[TB] FAIL accept_timeout addr=%h ready stayed 0 for %0d cycles", addr, waited);
          done = 1;
        end
        @(posedge clk);
      end
      @(negedge clk);
    end
    hbm_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Assert reset at a negedge; everything the model tracks except RAM contents is cleared
  task automatic doReset(input int hold);
    rst = 1'b1;
    hbm_req = 1'b0;
    sbq.delete();
    exp_wr = '0;
    exp_rd = '0;
    exp_oob = 1'b0;
    idle(hold);
    rst = 1'b0;
  endtask

  // Monitor: compares every cycle, just after the falling edge
  always @(negedge clk) begin
    exp_t e;
    bit   exp_ready;
    #1;
    if (rst) begin
      checkOutput("rst_ready", 256'(hbm_ready), 256'd0);
      checkOutput("rst_rvalid", 256'(rvalid), 256'd0);
      checkOutput("rst_refresh", 256'(refresh_active), 256'd0);
      checkOutput("rst_data", hbm_data_in, 256'd0);
      checkOutput("rst_err", 256'(err_oob), 256'd0);
      checkOutput("rst_wr_count", 256'(wr_count), 256'd0);
      checkOutput("rst_rd_count", 256'(rd_count), 256'd0);
    end else begin
      exp_ready = (k >= 1) && ((k % (RI + RC)) < RI);
      checkOutput("ready_pattern", 256'(hbm_ready), 256'(exp_ready));
      checkOutput("refresh_pattern", 256'(refresh_active), 256'((k >= 1) && !exp_ready));
      checkOutput("wr_count", 256'(wr_count), 256'(exp_wr));
      checkOutput("rd_count", 256'(rd_count), 256'(exp_rd));
      checkOutput("err_oob", 256'(err_oob), 256'(exp_oob));
      if (rvalid) begin
        if (sbq.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL rvalid_unexpected cycle=%0d data=%h", cyc, hbm_data_in);
        end else begin
          e = sbq.pop_front();
          checkOutput("rd_latency", 256'(cyc), 256'(e.cyc));
          if (!e.dc) checkOutput("rd_data", hbm_data_in, e.data);
        end
      end else if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
        checks++;
        fails++;
        $display("[TB] FAIL rvalid_missing cycle=%0d expected_at=%0d", cyc, sbq[0].cyc);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] a;
    int          bound;
    $display("[TB] start");
    idle(3);
    rst = 1'b0;
    idle(1);

    // Single write then read of the same word
    applyStimulus(1'b1, 32'h40, {32{8'hA5}});
    applyStimulus(1'b0, 32'h40, '0);

    // Sixteen back-to-back writes, then reads with random byte offsets
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'(32 * i), 256'(i));
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 32'(32 * i + $urandom_range(0, 31)), '0);
    applyStimulus(1'b0, 32'h1F, '0);

    // Out-of-range write is dropped; out-of-range read returns zeros
    applyStimulus(1'b1, 32'h8000, {8{32'hDEAD_BEEF}});
    applyStimulus(1'b0, 32'h0, '0);
    applyStimulus(1'b0, 32'h8000, '0);

    // Long burst of reads spanning several refresh windows
    for (int i = 0; i < 48; i++) applyStimulus(1'b0, 32'(32 * (i % 16)), '0);

    // Randomized traffic over a small window of words, with occasional out-of-range hits
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 99) < 8) a = $urandom | 32'h8000;
      else a = 32'($urandom_range(0, 63) * 32 + $urandom_range(0, 31));
      applyStimulus(1'($urandom_range(0, 1)), a, {8{$urandom}});
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    // Reset two cycles after a read accept: that read must never return
    applyStimulus(1'b0, 32'h40, '0);
    idle(1);
    doReset(3);
    idle(12);

    // Counter wrap on the preloaded instance
    checkOutput("wrap_wr_before", 256'(wr_count2), 256'(32'hFFFF_FFFF));
    we2 = 1'b1;
    req2 = 1'b1;
    bound = 0;
    while (!ready2 && bound < 20) begin
      bound++;
      idle(1);
    end
    checkOutput("wrap_ready", 256'(ready2), 256'd1);
    idle(1);
    we2 = 1'b0;
    idle(1);
    req2 = 1'b0;
    #1;
    checkOutput("wrap_wr_after", 256'(wr_count2), 256'd0);
    checkOutput("wrap_rd_after", 256'(rd_count2), 256'd0);

    idle(L + 4);
    checkOutput("scoreboard_empty", 256'(sbq.size()), 256'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
